// File: rtl/bpfcap_pkg.sv
// rtl/bpfcap_pkg.sv - shared types for the packet descriptor scheduler
// Purpose: scheduler state encoding, descriptor record and a length helper.
// Ports: none (package).
package bpfcap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } sched_state_t;

  typedef struct packed {
    logic [31:0] begin_addr;
    logic [31:0] end_addr;
  } desc_t;

  // Inclusive byte length, one bit wider than an address so that a full
  // 4 GiB span or an end-before-begin wrap cannot alias a legal length.
  function automatic logic [32:0] desc_len(input desc_t d);
    return {1'b0, d.end_addr} - {1'b0, d.begin_addr} + 33'd1;
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// rtl/desc_fifo.sv - first-word-fall-through circular buffer of descriptors
// Purpose: DEPTH-entry descriptor queue; head is valid whenever !empty.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write request and descriptor to store
//   pop                 consume the head entry
//   head                current oldest entry (fall-through)
//   full, empty, level  occupancy status
module desc_fifo
  import bpfcap_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  desc_t                    push_data,
  input  logic                     pop,
  output desc_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  desc_t          mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // A push into a full queue is accepted when the head leaves the same
  // cycle: the freed slot is the one being written.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_desc_sched.sv
// rtl/pkt_desc_sched.sv - validates, queues and dispatches packet descriptors
// Purpose: ingress descriptor check and queueing, one-at-a-time dispatch to
//          the capture engine with done/timeout handling, statistics.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   enable                        allows new dispatches (not enqueue)
//   desc_valid/desc_ready         ingress handshake
//   desc_begin/desc_end           inclusive byte range of the packet
//   pkt_begin/pkt_end/start       dispatch to the engine
//   engine_busy/engine_done       engine status and completion pulse
//   clr_stats                     clears counters and sticky flag
//   level                         queue occupancy
//   pkt_count/drop_count          completed / rejected descriptors
//   timeout_err                   sticky dispatch-timeout flag
module pkt_desc_sched
  import bpfcap_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 1518,
  parameter int TIMEOUT = 65535,
  parameter int CW      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [31:0]              desc_begin,
  input  logic [31:0]              desc_end,
  output logic [31:0]              pkt_begin,
  output logic [31:0]              pkt_end,
  output logic                     start,
  input  logic                     engine_busy,
  input  logic                     engine_done,
  input  logic                     clr_stats,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CW-1:0]            pkt_count,
  output logic [CW-1:0]            drop_count,
  output logic                     timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  sched_state_t   state;
  sched_state_t   state_next;
  desc_t          in_desc;
  desc_t          head;
  logic [32:0]    in_len;
  logic           desc_ok;
  logic           handshake;
  logic           push;
  logic           drop;
  logic           pop;
  logic           full;
  logic           empty;
  logic [TW-1:0]  tcnt;
  logic [TW-1:0]  tcnt_inc;
  logic           tmo_hit;
  logic           done_hit;

  // ---------------- ingress validation ----------------
  assign in_desc   = '{begin_addr: desc_begin, end_addr: desc_end};
  assign in_len    = desc_len(in_desc);
  assign desc_ok   = (desc_end >= desc_begin) && (in_len <= 33'(MAX_LEN));
  // Ready follows registered occupancy only, so a same-cycle pop never
  // opens the door for a push in that cycle.
  assign desc_ready = !full;
  assign handshake = desc_valid && desc_ready;
  assign push      = handshake && desc_ok;
  assign drop      = handshake && !desc_ok;

  desc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_desc),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // ---------------- scheduler FSM ----------------
  assign tcnt_inc = tcnt + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start      = 1'b0;
    done_hit   = 1'b0;
    tmo_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !empty && !engine_busy) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        start      = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as done.
        if (engine_done) begin
          done_hit   = 1'b1;
          state_next = IDLE;
        end else if (tcnt_inc == TW'(TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == ISSUE) begin
      tcnt <= '0;
    end else if (state == WAIT_DONE) begin
      tcnt <= tcnt_inc;
    end
  end

  // Dispatch registers hold until the next pop overwrites them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_begin <= '0;
      pkt_end   <= '0;
    end else if (pop) begin
      pkt_begin <= head.begin_addr;
      pkt_end   <= head.end_addr;
    end
  end

  // ---------------- statistics ----------------
  // Clear takes priority over a coincident increment; counts saturate.
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      pkt_count   <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (done_hit && (pkt_count != '1)) begin
        pkt_count <= pkt_count + 1'b1;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_desc_sched.sv
// tb/tb_pkt_desc_sched.sv - self-checking bench for pkt_desc_sched
module tb_pkt_desc_sched;
  import bpfcap_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  localparam int MAXL  = 1518;
  localparam int SCW   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_begin;
  logic [31:0] desc_end;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic        start;
  logic        engine_busy;
  logic        engine_done;
  logic        clr_stats;
  logic [4:0]  level;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic        timeout_err;

  logic        s_desc_ready;
  logic [31:0] s_pkt_begin;
  logic [31:0] s_pkt_end;
  logic        s_start;
  logic [4:0]  s_level;
  logic [SCW-1:0] s_pkt_count;
  logic [SCW-1:0] s_drop_count;
  logic        s_timeout_err;

  always #5 clk = ~clk;

  pkt_desc_sched #(.DEPTH(DEPTH), .MAX_LEN(MAXL), .TIMEOUT(TMO), .CW(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_begin(desc_begin), .desc_end(desc_end),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .start(start),
    .engine_busy(engine_busy), .engine_done(engine_done), .clr_stats(clr_stats),
    .level(level), .pkt_count(pkt_count), .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  // Narrow-counter instance on the same stimulus for saturation checks.
  pkt_desc_sched #(.DEPTH(DEPTH), .MAX_LEN(MAXL), .TIMEOUT(TMO), .CW(SCW)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .desc_valid(desc_valid),
    .desc_ready(s_desc_ready), .desc_begin(desc_begin), .desc_end(desc_end),
    .pkt_begin(s_pkt_begin), .pkt_end(s_pkt_end), .start(s_start),
    .engine_busy(engine_busy), .engine_done(engine_done), .clr_stats(clr_stats),
    .level(s_level), .pkt_count(s_pkt_count), .drop_count(s_drop_count),
    .timeout_err(s_timeout_err)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  desc_t mq[$];
  int    exp_pkt;
  int    exp_drop;
  int    cd;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    bit          ok;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, required event not seen", name);
  endtask

  // Reference acceptance rule: inclusive length between 1 and MAXL.
  function automatic bit ref_ok(input logic [31:0] b, input logic [31:0] e);
    longint bb;
    longint ee;
    longint len;
    bb  = b;
    ee  = e;
    len = ee - bb + 1;
    return (len >= 1) && (len <= MAXL);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic record(input logic [31:0] b, input logic [31:0] e);
    if (ref_ok(b, e)) mq.push_back('{begin_addr: b, end_addr: e});
    else exp_drop++;
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] e);
    int k;
    desc_begin = b;
    desc_end   = e;
    desc_valid = 1'b1;
    k = 0;
    while (!desc_ready && k < 50) begin
      tick();
      k++;
    end
    if (!desc_ready) begin
      expire("push_ready");
      desc_valid = 1'b0;
      return;
    end
    record(b, e);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_start(output bit got);
    int k;
    k = 0;
    while (!start && k < 100) begin
      tick();
      k++;
    end
    got = start;
    if (!got) expire("start_wait");
  endtask

  task automatic check_head(input string name);
    desc_t d;
    if (mq.size() == 0) begin
      expire({name, "_model_empty"});
      return;
    end
    d = mq.pop_front();
    check({name, "_begin"}, pkt_begin, d.begin_addr);
    check({name, "_end"}, pkt_end, d.end_addr);
  endtask

  task automatic serve(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      wait_start(got);
      if (!got) return;
      check_head("serve");
      tick();
      tick();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      exp_pkt++;
      check("serve_pkt_count", pkt_count, exp_pkt);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    desc_valid  = 1'b0;
    desc_begin  = '0;
    desc_end    = '0;
    engine_busy = 1'b0;
    engine_done = 1'b0;
    clr_stats   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    cd       = 0;
  endtask

  task automatic check_idle_state(input string name);
    check({name, "_level"}, level, 0);
    check({name, "_ready"}, desc_ready, 1);
    check({name, "_start"}, start, 0);
    check({name, "_pkt_begin"}, pkt_begin, 0);
    check({name, "_pkt_end"}, pkt_end, 0);
    check({name, "_pkt_count"}, pkt_count, 0);
    check({name, "_drop_count"}, drop_count, 0);
    check({name, "_timeout_err"}, timeout_err, 0);
  endtask

  // One cycle of the behavioural engine used by the random phase.
  task automatic engine_step();
    engine_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        engine_done = 1'b1;
        exp_pkt++;
      end
    end
    if (start) begin
      check_head("rand");
      cd = $urandom_range(1, 5);
    end
  endtask

  initial begin
    vec_t vecs[8];
    bit   got;
    int   lv;
    int   dr;
    logic [31:0] b;
    logic [31:0] e;
    int   kind;
    int   k;

    // ---------------- reset state ----------------
    do_reset();
    check_idle_state("reset");

    // ---------------- single descriptor, latency ----------------
    enable = 1'b1;
    push(32'h1000, 32'h103F);
    check("lat_c1_start", start, 0);
    check("lat_c1_level", level, 1);
    tick();
    check("lat_c2_start", start, 1);
    check_head("lat");
    check("lat_c2_level", level, 0);
    repeat (4) tick();
    engine_done = 1'b1;
    tick();
    engine_done = 1'b0;
    exp_pkt++;
    check("single_pkt_count", pkt_count, exp_pkt);
    check("single_level", level, 0);

    // ---------------- table of ingress validation vectors ----------------
    vecs[0] = '{32'h0000_2000, 32'h0000_1FFF, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'd1518,      1'b0};
    vecs[2] = '{32'h0000_0000, 32'd1517,      1'b1};
    vecs[3] = '{32'h0000_0010, 32'h0000_0010, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'hFFFF_FA22, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h8000_05EE, 1'b0};
    vecs[7] = '{32'h0000_0100, 32'h0000_00FF, 1'b0};
    enable = 1'b0;
    lv = 0;
    dr = 0;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].b, vecs[i].e);
      if (vecs[i].ok) lv++;
      else dr++;
      check($sformatf("vec%0d_level", i), level, lv);
      check($sformatf("vec%0d_drop", i), drop_count, dr);
      check($sformatf("vec%0d_start", i), start, 0);
    end
    enable = 1'b1;
    serve(lv);
    tick();
    check("vec_drain_level", level, 0);
    check("vec_drop_total", drop_count, exp_drop);

    // ---------------- fill to full, held 17th, refill on pop ----------------
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(32'h10_0000 + i * 32'h800, 32'h10_003F + i * 32'h800);
    check("full_level", level, DEPTH);
    check("full_ready", desc_ready, 0);
    desc_begin = 32'h20_0000;
    desc_end   = 32'h20_0100;
    desc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("held17_level_%0d", i), level, DEPTH);
    end
    enable = 1'b1;
    k = 0;
    while (!desc_ready && k < 10) begin
      check("full_pop_ready_low", desc_ready, 0);
      tick();
      k++;
    end
    if (!desc_ready) begin
      expire("full_refill_ready");
    end else begin
      check("full_refill_start", start, 1);
      check("full_refill_level", level, DEPTH - 1);
      check_head("full_first");
      record(desc_begin, desc_end);
      tick();
      desc_valid = 1'b0;
      check("full_after_push_level", level, DEPTH);
      tick();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      exp_pkt++;
    end
    serve(DEPTH);
    tick();
    check("full_drain_pkt_count", pkt_count, exp_pkt);
    check("full_drain_level", level, 0);

    // ---------------- timeout then next dispatch, then clear ----------------
    enable = 1'b0;
    push(32'h3000, 32'h30FF);
    push(32'h4000, 32'h40FF);
    enable = 1'b1;
    wait_start(got);
    if (got) begin
      check_head("tmo_first");
      repeat (7) tick();
      check("tmo_before_err", timeout_err, 0);
      tick();
      check("tmo_err_set", timeout_err, 1);
      check("tmo_pkt_count", pkt_count, exp_pkt);
      tick();
      check("tmo_next_start", start, 1);
      serve(1);
    end
    clr_stats = 1'b1;
    push(32'h500, 32'h4FF);
    clr_stats = 1'b0;
    exp_drop = 0;
    exp_pkt  = 0;
    check("clr_timeout_err", timeout_err, 0);
    check("clr_drop_count", drop_count, 0);
    check("clr_pkt_count", pkt_count, 0);

    // ---------------- busy hold, then reset during WAIT_DONE ----------------
    engine_busy = 1'b1;
    enable = 1'b0;
    push(32'h6000, 32'h6010);
    push(32'h7000, 32'h7010);
    push(32'h8000, 32'h8010);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("busy_nostart_%0d", i), start, 0);
    end
    check("busy_level", level, 3);
    engine_busy = 1'b0;
    tick();
    check("busy_release_start", start, 1);
    check_head("busy");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    check_idle_state("midreset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midreset_nostart_%0d", i), start, 0);
    end

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      engine_step();
      enable      = ($urandom_range(0, 3) != 0);
      engine_busy = ($urandom_range(0, 4) == 0);
      desc_valid  = ($urandom_range(0, 2) != 0);
      b    = $urandom() & 32'h7FFF_FFFF;
      kind = $urandom_range(0, 5);
      case (kind)
        3:       e = b + 32'd1517;
        4:       e = b + 32'd1518;
        5:       e = b - 32'd1 - 32'($urandom_range(0, 99));
        default: e = b + 32'($urandom_range(0, 1517));
      endcase
      desc_begin = b;
      desc_end   = e;
      if (desc_valid && desc_ready) record(b, e);
      tick();
    end
    desc_valid  = 1'b0;
    enable      = 1'b1;
    engine_busy = 1'b0;
    k = 0;
    while ((mq.size() > 0 || cd > 0) && k < 1000) begin
      engine_step();
      tick();
      k++;
    end
    engine_done = 1'b0;
    if (mq.size() > 0 || cd > 0) expire("rand_drain");
    tick();
    tick();
    check("rand_level", level, 0);
    check("rand_pkt_count", pkt_count, sat(exp_pkt, 65535));
    check("rand_drop_count", drop_count, sat(exp_drop, 65535));
    check("rand_timeout_err", timeout_err, 0);
    check("rand_sat_pkt_count", s_pkt_count, sat(exp_pkt, 7));
    check("rand_sat_drop_count", s_drop_count, sat(exp_drop, 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
